// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle processor control path:
// instruction field layout, opcodes and control FSM state encoding.
package cpu_pkg;

    localparam int IW  = 9;
    localparam int RNW = 3;

    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    function automatic logic [2:0] op_of(input logic [IW-1:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

    function automatic logic [RNW-1:0] rx_of(input logic [IW-1:0] ir);
        return ir[RX_HI:RX_LO];
    endfunction

    function automatic logic [RNW-1:0] ry_of(input logic [IW-1:0] ir);
        return ir[RY_HI:RY_LO];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the datapath:
// start/instruction inputs plus all register/bus steering strobes.
interface control_unit_if;
    import cpu_pkg::*;

    logic           run;
    logic [IW-1:0]  din;
    logic           ir_in;
    logic [RNW-1:0] src_num;
    logic           src_en;
    logic [RNW-1:0] dst_num;
    logic           dst_en;
    logic           din_out;
    logic           a_in;
    logic           g_in;
    logic           g_out;
    logic           add_sub;
    logic           done;

    modport master (
        input  run, din,
        output ir_in, src_num, src_en, dst_num, dst_en,
        output din_out, a_in, g_in, g_out, add_sub, done
    );

    modport slave (
        output run, din,
        input  ir_in, src_num, src_en, dst_num, dst_en,
        input  din_out, a_in, g_in, g_out, add_sub, done
    );

endinterface

// File: rtl/control_unit.sv
// Multi-cycle sequencer: latches the instruction word and walks
// mv/mvi/add/sub through T1..T3, steering bus source and write target.
module control_unit
    import cpu_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    control_unit_if.master bus
);

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   ir;
    logic [2:0]      op;
    logic [RNW-1:0]  rx;
    logic [RNW-1:0]  ry;

    assign op = op_of(ir);
    assign rx = rx_of(ir);
    assign ry = ry_of(ir);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (bus.ir_in) begin
                ir <= bus.din;
            end
        end
    end

    always_comb begin
        state_n     = state;
        bus.ir_in   = 1'b0;
        bus.src_num = '0;
        bus.src_en  = 1'b0;
        bus.dst_num = '0;
        bus.dst_en  = 1'b0;
        bus.din_out = 1'b0;
        bus.a_in    = 1'b0;
        bus.g_in    = 1'b0;
        bus.g_out   = 1'b0;
        bus.add_sub = 1'b0;
        bus.done    = 1'b0;

        case (state)
            T0: begin
                bus.ir_in = bus.run;
                if (bus.run) begin
                    state_n = T1;
                end
            end
            T1: begin
                unique case (1'b1)
                    (op == OP_MV): begin
                        bus.src_num = ry;
                        bus.src_en  = 1'b1;
                        bus.dst_num = rx;
                        bus.dst_en  = 1'b1;
                        bus.done    = 1'b1;
                        state_n     = T0;
                    end
                    (op == OP_MVI): begin
                        bus.din_out = 1'b1;
                        bus.dst_num = rx;
                        bus.dst_en  = 1'b1;
                        bus.done    = 1'b1;
                        state_n     = T0;
                    end
                    (op == OP_ADD || op == OP_SUB): begin
                        bus.src_num = rx;
                        bus.src_en  = 1'b1;
                        bus.a_in    = 1'b1;
                        state_n     = T2;
                    end
                    default: begin
                        // Illegal opcodes retire without touching any register
                        bus.done = 1'b1;
                        state_n  = T0;
                    end
                endcase
            end
            T2: begin
                bus.src_num = ry;
                bus.src_en  = 1'b1;
                bus.g_in    = 1'b1;
                bus.add_sub = op[0];
                state_n     = T3;
            end
            T3: begin
                bus.g_out   = 1'b1;
                bus.dst_num = rx;
                bus.dst_en  = 1'b1;
                bus.done    = 1'b1;
                state_n     = T0;
            end
            default: state_n = T0;
        endcase

        // Quiet every strobe during reset so no partial write can land
        if (reset) begin
            state_n     = T0;
            bus.ir_in   = 1'b0;
            bus.src_num = '0;
            bus.src_en  = 1'b0;
            bus.dst_num = '0;
            bus.dst_en  = 1'b0;
            bus.din_out = 1'b0;
            bus.a_in    = 1'b0;
            bus.g_in    = 1'b0;
            bus.g_out   = 1'b0;
            bus.add_sub = 1'b0;
            bus.done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed strobe vectors
// checked at the falling edge after each stimulus step.
module tb_control_unit;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    control_unit_if bus ();

    control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {ir_in, src_en, src_num, dst_en, dst_num, din_out, a_in, g_in, g_out, add_sub, done}
    function automatic logic [14:0] ev(
        input logic       ir,
        input logic       se,
        input logic [2:0] sn,
        input logic       de,
        input logic [2:0] dn,
        input logic       dio,
        input logic       ai,
        input logic       gi,
        input logic       go,
        input logic       as,
        input logic       dn_done
    );
        return {ir, se, sn, de, dn, dio, ai, gi, go, as, dn_done};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.ir_in, bus.src_en, bus.src_num, bus.dst_en, bus.dst_num,
                bus.din_out, bus.a_in, bus.g_in, bus.g_out, bus.add_sub,
                bus.done};
    endfunction

    task automatic step(input logic rst, input logic r, input logic [8:0] d);
        @(posedge clock);
        #1;
        reset   = rst;
        bus.run = r;
        bus.din = d;
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [14:0] exp_v);
        logic [14:0] o;
        o = obs();
        total++;
        assert (o === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, exp_v);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        bus.run = 1'b1;
        bus.din = 9'b000_010_101;
        @(negedge clock);
        check("reset_cycle", ev(0,0,0,0,0,0,0,0,0,0,0));

        step(0, 0, 9'h000);
        check("idle_after_reset", ev(0,0,0,0,0,0,0,0,0,0,0));

        // mv r2,r5
        step(0, 1, 9'b000_010_101);
        check("mv_fetch", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h000);
        check("mv_t1", ev(0,1,3'd5,1,3'd2,0,0,0,0,0,1));

        // mvi r7, #0x0A5
        step(0, 1, 9'b001_111_000);
        check("mvi_fetch", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h0A5);
        check("mvi_t1", ev(0,0,0,1,3'd7,1,0,0,0,0,1));

        // add r1,r3 with run toggled during T2
        step(0, 1, 9'b010_001_011);
        check("add_fetch", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h000);
        check("add_t1", ev(0,1,3'd1,0,0,0,1,0,0,0,0));
        step(0, 1, 9'b011_000_000);
        check("add_t2_run_ignored", ev(0,1,3'd3,0,0,0,0,1,0,0,0));
        step(0, 0, 9'h000);
        check("add_t3", ev(0,0,0,1,3'd1,0,0,0,1,0,1));

        // sub r4,r6
        step(0, 1, 9'b011_100_110);
        check("sub_fetch", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h000);
        check("sub_t1", ev(0,1,3'd4,0,0,0,1,0,0,0,0));
        step(0, 0, 9'h000);
        check("sub_t2", ev(0,1,3'd6,0,0,0,0,1,0,1,0));
        step(0, 0, 9'h000);
        check("sub_t3", ev(0,0,0,1,3'd4,0,0,0,1,0,1));

        // illegal opcode 111
        step(0, 1, 9'b111_010_001);
        check("ill_fetch", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h000);
        check("ill_t1", ev(0,0,0,0,0,0,0,0,0,0,1));

        // add r3,r3 interrupted by reset in T2
        step(0, 1, 9'b010_011_011);
        check("rst_add_fetch", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h000);
        check("rst_add_t1", ev(0,1,3'd3,0,0,0,1,0,0,0,0));
        step(1, 0, 9'h000);
        check("rst_in_t2", ev(0,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h000);
        check("rst_back_t0", ev(0,0,0,0,0,0,0,0,0,0,0));
        step(0, 0, 9'h000);
        check("rst_still_idle", ev(0,0,0,0,0,0,0,0,0,0,0));

        // run held high: mv r1,r2 ; mvi r3 ; mv r6,r7
        step(0, 1, 9'b000_001_010);
        check("b2b_fetch0", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 1, 9'b001_011_000);
        check("b2b_mv0", ev(0,1,3'd2,1,3'd1,0,0,0,0,0,1));
        step(0, 1, 9'b001_011_000);
        check("b2b_fetch1", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 1, 9'h155);
        check("b2b_mvi1", ev(0,0,0,1,3'd3,1,0,0,0,0,1));
        step(0, 1, 9'b000_110_111);
        check("b2b_fetch2", ev(1,0,0,0,0,0,0,0,0,0,0));
        step(0, 1, 9'b000_110_111);
        check("b2b_mv2", ev(0,1,3'd7,1,3'd6,0,0,0,0,0,1));
        step(0, 0, 9'h000);
        check("b2b_idle", ev(0,0,0,0,0,0,0,0,0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
